// File: rtl/mux16_pkg.sv
// Shared constants and types for the 16:1 bit multiplexer.
// Select codes are always in range: 4 bits address exactly 16 inputs.
package mux16_pkg;

    localparam int N_IN  = 16;
    localparam int SEL_W = 4;

    typedef logic [SEL_W-1:0] sel_t;

endpackage

// File: rtl/mux16_decode.sv
// Binary-to-one-hot decoder for the mux select.
// Every one of the 16 codes maps to exactly one set bit.
module mux16_decode
    import mux16_pkg::*;
(
    input  sel_t            sel,
    output logic [N_IN-1:0] oh
);

    // Set only the bit addressed by sel.
    always_comb begin
        oh      = '0;
        oh[sel] = 1'b1;
    end

endmodule

// File: rtl/mux16.sv
// 16:1 bit mux with one-hot decode and optional registered output.
// Define MUX16_REG_OUT_EN to build the out_q/out_vld capture stage.
module mux16
    import mux16_pkg::*;
#(
    parameter int N_IN  = 16,
    parameter int SEL_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_IN-1:0]  in,
    input  logic [SEL_W-1:0] sel,
    input  logic             en,
    output logic             out,
    output logic [N_IN-1:0]  sel_oh,
    output logic             out_q,
    output logic             out_vld
);

    mux16_decode u_decode (
        .sel (sel),
        .oh  (sel_oh)
    );

    // AND-OR select keeps out known whenever in and sel are known.
    always_comb begin
        out = |(sel_oh & in);
    end

`ifdef MUX16_REG_OUT_EN

    // Capture the selected bit on enabled edges; reset drops the held value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q   <= 1'b0;
            out_vld <= 1'b0;
        end else begin
            if (en) begin
                out_q <= out;
            end
            out_vld <= en;
        end
    end

`else

    logic unused_ctrl;

    // No storage: the registered view is simply the live mux output.
    always_comb begin
        out_q       = out;
        out_vld     = 1'b1;
        unused_ctrl = ^{clk, rst_n, en};
    end

`endif

endmodule

// File: tb/tb_mux16.sv
// Self-checking bench for mux16 against a shift-based reference model.
// Registered-stage checks are built when MUX16_REG_OUT_EN is defined.
module tb_mux16;

    logic        clk;
    logic        rst_n;
    logic [15:0] in;
    logic [3:0]  sel;
    logic        en;
    logic        out;
    logic [15:0] sel_oh;
    logic        out_q;
    logic        out_vld;

    int vectors;
    int miscompares;

    logic m_q;
    logic m_vld;

    mux16 #(
        .N_IN  (16),
        .SEL_W (4)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .in      (in),
        .sel     (sel),
        .en      (en),
        .out     (out),
        .sel_oh  (sel_oh),
        .out_q   (out_q),
        .out_vld (out_vld)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic ref_bit(logic [15:0] d, logic [3:0] s);
        logic [15:0] t;
        t = d >> s;
        return t[0];
    endfunction

    function automatic logic [15:0] ref_oh(logic [3:0] s);
        return 16'h0001 << s;
    endfunction

    task automatic check(string tag, logic [15:0] obs, logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_comb(string tag);
        check({tag, ".out"}, {15'd0, out}, {15'd0, ref_bit(in, sel)});
        check({tag, ".oh"}, sel_oh, ref_oh(sel));
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        m_q         = 1'b0;
        m_vld       = 1'b0;
        rst_n       = 1'b0;
        en          = 1'b0;
        in          = 16'h0000;
        sel         = 4'd0;

        #12;
`ifdef MUX16_REG_OUT_EN
        check("rst_q", {15'd0, out_q}, 16'd0);
        check("rst_vld", {15'd0, out_vld}, 16'd0);
`else
        check("rst_q", {15'd0, out_q}, 16'd0);
        check("rst_vld", {15'd0, out_vld}, 16'd1);
`endif
        in  = 16'hC3A5;
        sel = 4'd7;
        #1;
        check_comb("rst_comb");

        // Alternating pattern: even selects read 1, odd read 0.
        in = 16'b0101010101010101;
        for (int s = 0; s < 16; s++) begin
            sel = s[3:0];
            #5;
            check("alt.out", {15'd0, out}, {15'd0, (s % 2 == 0)});
            check("alt.oh", sel_oh, ref_oh(s[3:0]));
        end

        in  = 16'h8000;
        sel = 4'd15;
        #1;
        check("msb.hi", {15'd0, out}, 16'd1);
        sel = 4'd14;
        #1;
        check("msb.lo", {15'd0, out}, 16'd0);

`ifndef MUX16_REG_OUT_EN
        in  = 16'hAAAA;
        sel = 4'd3;
        #1;
        check("comb.q", {15'd0, out_q}, 16'd1);
        check("comb.vld", {15'd0, out_vld}, 16'd1);
`endif

        @(negedge clk);
        rst_n = 1'b1;

        // Random traffic checked against the reference model.
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            in  = 16'($urandom);
            sel = 4'($urandom);
            en  = 1'($urandom);
            #1;
            check_comb("rnd.pre");
            @(posedge clk);
            if (en) m_q = ref_bit(in, sel);
            m_vld = en;
            #1;
            check_comb("rnd.post");
`ifdef MUX16_REG_OUT_EN
            check("rnd.q", {15'd0, out_q}, {15'd0, m_q});
            check("rnd.vld", {15'd0, out_vld}, {15'd0, m_vld});
`else
            check("rnd.q", {15'd0, out_q}, {15'd0, ref_bit(in, sel)});
            check("rnd.vld", {15'd0, out_vld}, 16'd1);
`endif
        end

`ifdef MUX16_REG_OUT_EN
        // Capture once, then hold while inputs change.
        @(negedge clk);
        in  = 16'h0001;
        sel = 4'd0;
        en  = 1'b1;
        @(posedge clk);
        #1;
        check("cap.q", {15'd0, out_q}, 16'd1);
        check("cap.vld", {15'd0, out_vld}, 16'd1);
        @(negedge clk);
        en = 1'b0;
        in = 16'h0000;
        @(posedge clk);
        #1;
        check("hold.q", {15'd0, out_q}, 16'd1);
        check("hold.vld", {15'd0, out_vld}, 16'd0);
        check("hold.out", {15'd0, out}, 16'd0);

        // Asynchronous reset mid-cycle clears the held bit.
        #2;
        rst_n = 1'b0;
        #1;
        check("arst.q", {15'd0, out_q}, 16'd0);
        check("arst.vld", {15'd0, out_vld}, 16'd0);
        in = 16'h0010;
        sel = 4'd4;
        #1;
        check_comb("arst.comb");

        // First enabled edge after release raises out_vld.
        @(negedge clk);
        rst_n = 1'b1;
        en    = 1'b1;
        @(posedge clk);
        #1;
        check("rel.q", {15'd0, out_q}, 16'd1);
        check("rel.vld", {15'd0, out_vld}, 16'd1);
        @(negedge clk);
        en = 1'b0;
`else
        // Reset has no effect on the flop-free build.
        @(negedge clk);
        in    = 16'h0400;
        sel   = 4'd10;
        rst_n = 1'b0;
        #1;
        check_comb("nrst.comb");
        check("nrst.q", {15'd0, out_q}, 16'd1);
        check("nrst.vld", {15'd0, out_vld}, 16'd1);
        rst_n = 1'b1;
`endif

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mux16.md
MUX16 -- requirements
Module: mux16

Interface
- Parameters: name, default, meaning.
  - REQ-001 The module SHALL declare parameter N_IN, default 16, meaning the number of data inputs; only the value 16 is supported.
  - REQ-002 The module SHALL declare parameter SEL_W, default 4, meaning the select width; it SHALL equal log2(N_IN).
- Ports: name, direction, width, meaning.
  - REQ-003 clk, input, 1, single clock for all sequential logic.
  - REQ-004 rst_n, input, 1, asynchronous active-low reset.
  - REQ-005 in, input, 16, data inputs; bit k is candidate k.
  - REQ-006 sel, input, 4, binary index of the selected input.
  - REQ-007 en, input, 1, capture enable for the registered stage.
  - REQ-008 out, output, 1, combinational selected bit.
  - REQ-009 sel_oh, output, 16, combinational one-hot decode of sel.
  - REQ-010 out_q, output, 1, registered selected bit.
  - REQ-011 out_vld, output, 1, qualifies out_q.

Function
- REQ-012 out SHALL equal in[sel] combinationally, with zero clock latency; a change on in or sel SHALL propagate without any clk edge.
- REQ-013 sel_oh SHALL have exactly bit sel set and all other bits clear, for every sel value 0..15.
- REQ-014 All 16 sel codes are legal; no out-of-range or default-to-X case SHALL exist.
- REQ-015 out SHALL be built as the OR over k of (sel_oh[k] AND in[k]), so it is never X when in and sel are known.
- REQ-016 When en=1 on a rising clk edge, out_q SHALL load in[sel] sampled at that edge and out_vld SHALL be 1 in the following cycle.
- REQ-017 When en=0 on a rising clk edge, out_q SHALL hold its value and out_vld SHALL be 0 in the following cycle.
- REQ-018 If in or sel changes in the same cycle as an en=1 edge, the values present at the edge SHALL be captured.

Reset
- REQ-019 While rst_n=0, out_q=0 and out_vld=0 SHALL hold immediately, independent of clk.
- REQ-020 out and sel_oh SHALL remain purely combinational and be unaffected by rst_n.
- REQ-021 On rst_n deassertion, the first rising clk edge with en=1 SHALL produce out_vld=1 one cycle later.
- REQ-022 Asserting rst_n mid-operation SHALL discard the held out_q value.

Configuration
- REQ-023 With macro MUX16_REG_OUT_EN defined, out_q and out_vld SHALL behave per REQ-016 to REQ-019.
- REQ-024 Without MUX16_REG_OUT_EN, no flops SHALL be instantiated: out_q SHALL equal out combinationally, and out_vld SHALL be constant 1; clk, rst_n and en SHALL be unused.

Structure
- REQ-025 Package mux16_pkg SHALL hold the constants N_IN=16 and SEL_W=4 and the typedef sel_t (logic [3:0]).
- REQ-026 The decoder SHALL be a sub-module mux16_decode (sel_t in, 16-bit one-hot out), instantiated once.

Verification
- REQ-027 in=16'b0101010101010101, sel stepped 0..15 every 5 time units with no clock -> out=1 for even sel and 0 for odd sel, and sel_oh=1<<sel at each step.
- REQ-028 in=16'h8000, sel=15 -> out=1; then sel=14 -> out=0.
- REQ-029 rst_n=0 asynchronously mid-cycle with out_q=1 -> out_q=0 and out_vld=0 before the next clk edge.
- REQ-030 MUX16_REG_OUT_EN defined, in=16'h0001, sel=0, en=1 for one edge, then en=0 and in=0 -> out_q=1 held with out_vld=0, while out=0.
- REQ-031 MUX16_REG_OUT_EN undefined, in=16'hAAAA, sel=3 -> out_q=1 and out_vld=1 with no clock applied.
